// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: frame sequencer states, position counter
// width, default frame geometry (also used by line_buffer) and the pixel
// position payload.
package img_pkg;

  localparam int unsigned CNT_W          = 9;
  localparam int unsigned DEF_IMG_WIDTH  = 480;
  localparam int unsigned DEF_IMG_HEIGHT = 360;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } lb_state_e;

  // Row/column of a pixel within the frame.
  typedef struct packed {
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
  } pix_pos_t;

endpackage : img_pkg

// File: rtl/pix_pos_counter.sv
// Column/row position counter for accepted pixels.
//   clk, rst_n   : clock, async active-low reset
//   clr          : return to (0,0); wins over adv
//   adv          : a pixel was accepted this cycle, step to the next position
//   pos          : position of the next pixel to be accepted (registered)
//   last_col_c   : pos is in the last column
//   last_pix_c   : pos is the last pixel of the frame
module pix_pos_counter
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  input  logic     adv,
  output pix_pos_t pos,
  output logic     last_col_c,
  output logic     last_pix_c
);

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_HEIGHT - 1);

  pix_pos_t pos_q;

  // Column wraps to 0 and bumps the row; the frame end is handled by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else if (clr) begin
      pos_q <= '0;
    end else if (adv) begin
      if (last_col_c) begin
        pos_q.col <= '0;
        pos_q.row <= pos_q.row + CNT_W'(1);
      end else begin
        pos_q.col <= pos_q.col + CNT_W'(1);
      end
    end
  end

  assign pos        = pos_q;
  assign last_col_c = (pos_q.col == COL_MAX);
  assign last_pix_c = last_col_c && (pos_q.row == ROW_MAX);

endmodule : pix_pos_counter

// File: rtl/linebuf_seq_ctrl.sv
// Frame sequencer for the two-stage line-buffer chain feeding the 3x3 window
// datapath: gates pixel writes, tracks pixel position, strobes complete
// windows, and flushes the line buffers between frames and on framing errors.
//   clk, rst_n : clock, async active-low reset
//   frame_en   : frames accepted only while high
//   pix_valid  : pixel strobe (no backpressure)
//   sof_in     : start of frame, qualified by pix_valid
//   err_clr    : clears sticky error flags (a same-cycle new error wins)
//   lb_wr_en   : combinational write enable into the first line buffer
//   lb_rst_n   : registered active-low reset to all line buffers
//   win_valid  : a full 3x3 window is at the chain outputs
//   win_row/col: centre of that window
//   eof        : pulse one cycle after the last pixel of a frame
//   busy       : sequencer not idle
//   err_sync   : sticky, sof arrived mid-frame
//   err_drop   : sticky, pixel dropped in IDLE (no sof) or FLUSH
module linebuf_seq_ctrl
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_en,
  input  logic             pix_valid,
  input  logic             sof_in,
  input  logic             err_clr,
  output logic             lb_wr_en,
  output logic             lb_rst_n,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             eof,
  output logic             busy,
  output logic             err_sync,
  output logic             err_drop
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_FILL  = 2'(ST_FILL);
  localparam logic [1:0] S_RUN   = 2'(ST_RUN);
  localparam logic [1:0] S_FLUSH = 2'(ST_FLUSH);

  localparam int unsigned     FL_W    = 4;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [FL_W-1:0]  flush_cnt_q;
  logic             wr_c, win_hit_c, eof_hit_c, set_sync_c, set_drop_c;
  logic             cnt_clr_c;
  pix_pos_t         pos;
  logic             last_col_c, last_pix_c;

  logic             lb_rst_n_q, win_valid_q, eof_q, busy_q;
  logic             err_sync_q, err_drop_q;
  logic [CNT_W-1:0] win_row_q, win_col_q;

  pix_pos_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr_c),
    .adv       (wr_c),
    .pos       (pos),
    .last_col_c(last_col_c),
    .last_pix_c(last_pix_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, pixel acceptance and event decode.
  always_comb begin
    state_d    = state_q;
    wr_c       = 1'b0;
    win_hit_c  = 1'b0;
    eof_hit_c  = 1'b0;
    set_sync_c = 1'b0;
    set_drop_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pix_valid) begin
          if (sof_in && frame_en) begin
            wr_c    = 1'b1;
            state_d = S_FILL;
          end else if (!sof_in) begin
            set_drop_c = 1'b1;
          end
        end
      end
      S_FILL, S_RUN: begin
        if (pix_valid && sof_in) begin
          // Resync: the pixel is not written, the partial frame is discarded.
          set_sync_c = 1'b1;
          state_d    = S_FLUSH;
        end else begin
          if (pix_valid) begin
            wr_c = 1'b1;
            if (last_pix_c) begin
              eof_hit_c = 1'b1;
              state_d   = S_FLUSH;
            end else if (state_q == S_FILL && last_col_c && pos.row == CNT_W'(1)) begin
              state_d = S_RUN;
            end
            // Window centre lags the incoming pixel by one row and column.
            if (state_q == S_RUN && pos.col >= CNT_W'(2)) win_hit_c = 1'b1;
          end
          if (!frame_en) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pix_valid) set_drop_c = 1'b1;
        if (flush_cnt_q == FL_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_clr_c = (state_d == S_FLUSH) && (state_q != S_FLUSH);

  // Flush timer: counts cycles spent in FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  flush_cnt_q <= '0;
    else if (state_q == S_FLUSH) flush_cnt_q <= flush_cnt_q + FL_W'(1);
    else                         flush_cnt_q <= '0;
  end

  // Registered outputs; lb_rst_n and busy follow the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_rst_n_q  <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_sync_q  <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      lb_rst_n_q  <= (state_d != S_FLUSH);
      win_valid_q <= win_hit_c;
      if (win_hit_c) begin
        win_row_q <= pos.row - CNT_W'(1);
        win_col_q <= pos.col - CNT_W'(1);
      end
      eof_q       <= eof_hit_c;
      busy_q      <= (state_d != S_IDLE);
      err_sync_q  <= set_sync_c | (err_sync_q & ~err_clr);
      err_drop_q  <= set_drop_c | (err_drop_q & ~err_clr);
    end
  end

  assign lb_wr_en  = wr_c;
  assign lb_rst_n  = lb_rst_n_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign err_sync  = err_sync_q;
  assign err_drop  = err_drop_q;

endmodule : linebuf_seq_ctrl

// File: tb/tb_linebuf_seq_ctrl.sv
// Directed bench for linebuf_seq_ctrl on a small 6x5 frame.
module tb_linebuf_seq_ctrl;

  localparam int unsigned W  = 6;
  localparam int unsigned H  = 5;
  localparam int unsigned FC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_en, pix_valid, sof_in, err_clr;
  logic       lb_wr_en, lb_rst_n, win_valid, eof, busy, err_sync, err_drop;
  logic [8:0] win_row, win_col;

  int tests_run    = 0;
  int tests_failed = 0;
  int win_cnt;

  linebuf_seq_ctrl #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_en (frame_en),
    .pix_valid(pix_valid),
    .sof_in   (sof_in),
    .err_clr  (err_clr),
    .lb_wr_en (lb_wr_en),
    .lb_rst_n (lb_rst_n),
    .win_valid(win_valid),
    .win_row  (win_row),
    .win_col  (win_col),
    .eof      (eof),
    .busy     (busy),
    .err_sync (err_sync),
    .err_drop (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel strobe; lb_wr_en is checked before the capturing edge.
  task automatic drive_pix(input logic sof, input logic exp_wr);
    pix_valid = 1'b1;
    sof_in    = sof;
    #1;
    check("lb_wr_en", 32'(lb_wr_en), 32'(exp_wr));
    tick();
    pix_valid = 1'b0;
    sof_in    = 1'b0;
  endtask

  // Send pixels first..last (raster index), sof on index 0, optional gaps.
  task automatic send_pixels(input int first, input int last, input bit gaps);
    int r, c, n;
    bit exp_win;
    for (int idx = first; idx <= last; idx++) begin
      r = idx / int'(W);
      c = idx % int'(W);
      if (gaps) begin
        n = int'($urandom_range(0, 3));
        for (int g = 0; g < n; g++) begin
          tick();
          check("gap_win_valid", 32'(win_valid), 32'd0);
        end
      end
      drive_pix(idx == 0, 1'b1);
      exp_win = (r >= 2) && (c >= 2);
      check("win_valid", 32'(win_valid), 32'(exp_win));
      if (exp_win) begin
        win_cnt++;
        check("win_row", 32'(win_row), 32'(r - 1));
        check("win_col", 32'(win_col), 32'(c - 1));
      end
      check("eof", 32'(eof), 32'(idx == int'(W * H) - 1));
    end
  endtask

  // Count cycles with lb_rst_n low (bounded), then expect idle.
  task automatic measure_flush(input int exp_len);
    int cnt = 0;
    while (lb_rst_n == 1'b0 && cnt < 20) begin
      cnt++;
      tick();
    end
    check("flush_len", 32'(cnt), 32'(exp_len));
    check("busy_after_flush", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; frame_en = 1'b0; pix_valid = 1'b0; sof_in = 1'b0; err_clr = 1'b0;
    tick(); tick();
    // Reset values
    check("rst_lb_rst_n", 32'(lb_rst_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_win_valid", 32'(win_valid), 32'd0);
    check("rst_eof", 32'(eof), 32'd0);
    check("rst_err", 32'({err_sync, err_drop}), 32'd0);
    check("rst_win_pos", 32'({win_row, win_col}), 32'd0);
    rst_n = 1'b1;
    tick();
    check("lb_rst_n_release", 32'(lb_rst_n), 32'd1);

    // Full contiguous frame: 4*3 windows, first (1,1), last (3,4)
    frame_en = 1'b1;
    win_cnt  = 0;
    send_pixels(0, int'(W * H) - 1, 1'b0);
    check("frame_win_cnt", 32'(win_cnt), 32'd12);
    check("last_win_pos", 32'({win_row, win_col}), 32'({9'd3, 9'd4}));
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_lb_rst_n", 32'(lb_rst_n), 32'd0);
    tick();
    check("eof_pulse_end", 32'(eof), 32'd0);
    measure_flush(FC - 1);

    // Same frame with random gaps
    win_cnt = 0;
    send_pixels(0, int'(W * H) - 1, 1'b1);
    check("gap_win_cnt", 32'(win_cnt), 32'd12);
    measure_flush(FC);

    // Mid-frame sof at (3,2)
    send_pixels(0, 3 * int'(W) + 1, 1'b0);
    drive_pix(1'b1, 1'b0);
    check("sync_err_sync", 32'(err_sync), 32'd1);
    check("sync_no_eof", 32'(eof), 32'd0);
    check("sync_win_valid", 32'(win_valid), 32'd0);
    check("sync_busy", 32'(busy), 32'd1);
    measure_flush(FC);
    win_cnt = 0;
    send_pixels(0, int'(W * H) - 1, 1'b0);
    check("clean_win_cnt", 32'(win_cnt), 32'd12);
    check("err_sync_sticky", 32'(err_sync), 32'd1);
    measure_flush(FC);

    // Stray pixels in IDLE and err_clr behaviour
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_sync_cleared", 32'(err_sync), 32'd0);
    drive_pix(1'b0, 1'b0);
    check("idle_drop", 32'(err_drop), 32'd1);
    check("idle_drop_busy", 32'(busy), 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("drop_cleared", 32'(err_drop), 32'd0);
    err_clr = 1'b1;
    drive_pix(1'b0, 1'b0);
    err_clr = 1'b0;
    check("clr_vs_set", 32'(err_drop), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("drop_cleared2", 32'(err_drop), 32'd0);

    // Stray pixel during FLUSH
    send_pixels(0, int'(W * H) - 1, 1'b0);
    drive_pix(1'b0, 1'b0);
    check("flush_drop", 32'(err_drop), 32'd1);
    measure_flush(FC - 1);

    // frame_en dropped at row 3: windows (2,2..5) and (3,2)
    win_cnt = 0;
    send_pixels(0, 3 * int'(W) + 2, 1'b0);
    frame_en = 1'b0;
    tick();
    check("fen_lb_rst_n", 32'(lb_rst_n), 32'd0);
    check("fen_busy", 32'(busy), 32'd1);
    check("fen_win_valid", 32'(win_valid), 32'd0);
    check("fen_no_eof", 32'(eof), 32'd0);
    check("fen_win_cnt", 32'(win_cnt), 32'd5);
    measure_flush(FC);

    // Async reset mid-RUN
    frame_en = 1'b1;
    send_pixels(0, 3 * int'(W) + 3, 1'b0);
    check("pre_rst_win_valid", 32'(win_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_win_valid", 32'(win_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_lb_rst_n", 32'(lb_rst_n), 32'd0);
    check("arst_win_pos", 32'({win_row, win_col}), 32'd0);
    check("arst_err_eof", 32'({eof, err_sync, err_drop}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_lb_rst_n_hold", 32'(lb_rst_n), 32'd0);
    tick();
    check("arst_lb_rst_n_rise", 32'(lb_rst_n), 32'd1);

    // Clean frame after async reset
    win_cnt = 0;
    send_pixels(0, int'(W * H) - 1, 1'b0);
    check("post_rst_win_cnt", 32'(win_cnt), 32'd12);
    measure_flush(FC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_linebuf_seq_ctrl
